dlx_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares one read/write memory (the `mem_interface` rw-style memory model: ENABLE, READNOTWRITE, ADDRESS, INOUT_DATA, DATA_READY) between the DLX instruction-fetch port and the load/store data port. It sits between the core and the test-bench memory. It serialises accesses with round-robin fairness and holds the memory strobes stable until DATA_READY. It returns a one-cycle acknowledge per access and flags accesses that never complete.

---
 rtl/dlx_mem_arb_pkg.sv | 8 +
 rtl/dlx_mem_rr_picker.sv | 14 +
 rtl/dlx_mem_arbiter.sv | 109 ++++++++++
 tb/tb_dlx_mem_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dlx_mem_arb_pkg.sv
// dlx_mem_arb_pkg: shared types and default sizing for the DLX memory arbiter
package dlx_mem_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
  typedef enum logic {PORT_IF, PORT_D} port_id_t;
  localparam int WORD_SIZE_DEF    = 32;
  localparam int ADDRESS_SIZE_DEF = 16;
  localparam int TIMEOUT_DEF      = 16;
endpackage

// File: rtl/dlx_mem_rr_picker.sv
// dlx_mem_rr_picker: two-way round-robin choice, a tie goes to the port not served last
module dlx_mem_rr_picker
  import dlx_mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_id_t   last_i,
  output port_id_t   winner_o,
  output logic       valid_o
);
  always_comb begin
    winner_o = &req_i ? (last_i == PORT_IF ? PORT_D : PORT_IF) : (req_i[1] ? PORT_D : PORT_IF);
    valid_o  = |req_i;
  end
endmodule

// File: rtl/dlx_mem_arbiter.sv
// dlx_mem_arbiter: shares one rw memory between DLX fetch and load/store ports
module dlx_mem_arbiter
  import dlx_mem_arb_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDRESS_SIZE-1:0] if_addr,
  output logic [WORD_SIZE-1:0]    if_rdata,
  output logic                    if_ack,
  output logic                    if_err,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDRESS_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0]    d_wdata,
  output logic [WORD_SIZE-1:0]    d_rdata,
  output logic                    d_ack,
  output logic                    d_err,
  output logic                    mem_enable,
  output logic                    mem_readnotwrite,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0]    mem_wdata,
  output logic                    mem_data_oe,
  input  logic [WORD_SIZE-1:0]    mem_rdata,
  input  logic                    mem_data_ready
);
  localparam int CW = $clog2(TIMEOUT + 1);
  arb_state_t state_q;
  port_id_t last_q, port_q, pick;
  logic pick_valid, pick_we, we_q, done, tmo;
  logic [CW-1:0] cnt_q, cnt_d;
  dlx_mem_rr_picker u_pick (
    .req_i    ({d_req, if_req}),
    .last_i   (last_q),
    .winner_o (pick),
    .valid_o  (pick_valid)
  );
  // the first ACCESS cycle (cnt_q == 0) sees a stale DATA_READY and is ignored
  assign cnt_d   = cnt_q + 1'b1;
  assign done    = (cnt_q != '0) && mem_data_ready;
  assign tmo     = cnt_d == CW'(TIMEOUT);
  assign pick_we = (pick == PORT_D) && d_we;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ARB_IDLE;
      last_q           <= PORT_IF;
      port_q           <= PORT_IF;
      we_q             <= 1'b0;
      cnt_q            <= '0;
      if_rdata         <= '0;
      if_ack           <= 1'b0;
      if_err           <= 1'b0;
      d_rdata          <= '0;
      d_ack            <= 1'b0;
      d_err            <= 1'b0;
      mem_enable       <= 1'b0;
      mem_readnotwrite <= 1'b0;
      mem_address      <= '0;
      mem_wdata        <= '0;
      mem_data_oe      <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: if (pick_valid) begin
          state_q          <= ARB_ACCESS;
          port_q           <= pick;
          we_q             <= pick_we;
          cnt_q            <= '0;
          mem_enable       <= 1'b1;
          mem_readnotwrite <= !pick_we;
          mem_address      <= pick == PORT_D ? d_addr : if_addr;
          mem_wdata        <= pick_we ? d_wdata : '0;
          mem_data_oe      <= pick_we;
        end
        ARB_ACCESS: begin
          cnt_q <= cnt_d;
          if (done || tmo) begin
            state_q     <= ARB_RESP;
            mem_enable  <= 1'b0;
            mem_data_oe <= 1'b0;
            if (port_q == PORT_D) begin
              d_ack   <= 1'b1;
              d_err   <= !done;
              d_rdata <= (done && !we_q) ? mem_rdata : '0;
            end else begin
              if_ack   <= 1'b1;
              if_err   <= !done;
              if_rdata <= done ? mem_rdata : '0;
            end
          end
        end
        ARB_RESP: begin
          state_q  <= ARB_IDLE;
          last_q   <= port_q;
          if_ack   <= 1'b0;
          if_err   <= 1'b0;
          if_rdata <= '0;
          d_ack    <= 1'b0;
          d_err    <= 1'b0;
          d_rdata  <= '0;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// tb_dlx_mem_arbiter: directed stimulus, memory model and edge-level reference model
module tb_dlx_mem_arbiter;
  localparam int TMO = 16;
  logic clk, rst;
  logic if_req, if_ack, if_err, d_req, d_we, d_ack, d_err;
  logic [15:0] if_addr, d_addr, mem_address;
  logic [31:0] if_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic mem_enable, mem_readnotwrite, mem_data_oe, mem_data_ready;

  dlx_mem_arbiter #(.WORD_SIZE(32), .ADDRESS_SIZE(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_enable(mem_enable), .mem_readnotwrite(mem_readnotwrite), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_data_oe(mem_data_oe), .mem_rdata(mem_rdata),
    .mem_data_ready(mem_data_ready)
  );

  int checks = 0, errors = 0, cyc = 0;
  int mode = 0;
  logic [31:0] mem [0:65535];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // memory: mode 0 ready on the 2nd enabled cycle, mode 1 ready stuck high, mode 2 stuck low
  int en_cnt = 0;
  initial begin
    mem_data_ready = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      en_cnt = mem_enable ? en_cnt + 1 : 0;
      mem_data_ready = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : (mem_enable && en_cnt >= 2);
      if (mem_enable && mem_data_ready && mem_data_oe && !mem_readnotwrite) mem[mem_address] = mem_wdata;
      mem_rdata = (mem_enable && mem_data_ready) ? mem[mem_address] : 32'hA5A5_A5A5;
    end
  end

  // reference model: edge arithmetic on the start edge N of each access
  bit m_act = 0, m_port = 0, m_we = 0, m_last = 0, pristine = 1, chk_on = 0;
  logic [15:0] m_addr = 0;
  logic [31:0] m_wdata = 0;
  int m_n = 0, free_edge = 0;
  bit e_if_ack = 0, e_if_err = 0, e_d_ack = 0, e_d_err = 0;
  logic [31:0] e_if_rdata = 0, e_d_rdata = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
    e_if_ack = 0; e_if_err = 0; e_d_ack = 0; e_d_err = 0; e_if_rdata = 0; e_d_rdata = 0;
    if (rst) begin
      m_act = 0; m_last = 0; free_edge = 0; pristine = 1; chk_on = 1;
    end else if (m_act) begin
      bit fin, err;
      fin = (cyc - m_n >= 2 && mem_data_ready) || (cyc - m_n == TMO);
      err = !(cyc - m_n >= 2 && mem_data_ready);
      if (fin) begin
        if (m_port) begin
          e_d_ack = 1; e_d_err = err; e_d_rdata = (err || m_we) ? 32'h0 : mem_rdata;
        end else begin
          e_if_ack = 1; e_if_err = err; e_if_rdata = err ? 32'h0 : mem_rdata;
        end
        m_act = 0; free_edge = cyc + 2; m_last = m_port;
      end
    end else if (cyc >= free_edge && (if_req || d_req)) begin
      m_port  = (if_req && d_req) ? !m_last : d_req;
      m_we    = m_port && d_we;
      m_addr  = m_port ? d_addr : if_addr;
      m_wdata = d_wdata;
      m_n = cyc; m_act = 1; pristine = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("if_ack", 32'(if_ack), 32'(e_if_ack));
      chk("if_err", 32'(if_err), 32'(e_if_err));
      chk("if_rdata", if_rdata, e_if_rdata);
      chk("d_ack", 32'(d_ack), 32'(e_d_ack));
      chk("d_err", 32'(d_err), 32'(e_d_err));
      chk("d_rdata", d_rdata, e_d_rdata);
      chk("mem_enable", 32'(mem_enable), 32'(m_act));
      chk("mem_data_oe", 32'(mem_data_oe), 32'(m_act && m_we));
      if (m_act) begin
        chk("mem_address", 32'(mem_address), 32'(m_addr));
        chk("mem_rnw", 32'(mem_readnotwrite), 32'(!m_we));
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end else if (pristine) begin
        chk("rst_address", 32'(mem_address), 32'h0);
        chk("rst_rnw", 32'(mem_readnotwrite), 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
      end
    end
  end

  task automatic wait_ack(input bit p, input int t0, output int dt);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p ? d_ack : if_ack) && n < 60);
    chk(p ? "d_ack_seen" : "if_ack_seen", 32'(p ? d_ack : if_ack), 32'h1);
    dt = cyc - t0;
  endtask

  int t0, dt, prev, who;
  int exp_ord [4] = '{1, 0, 1, 0};
  initial begin
    rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem[16'h0010] = 32'hDEAD_BEEF;
    mem[16'h0020] = 32'h0;
    mem[16'h0030] = 32'hAAAA_0001;
    mem[16'h0040] = 32'hBBBB_0002;
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (10) begin
      @(negedge clk);
      chk("idle_enable", 32'(mem_enable), 32'h0);
    end
    // fetch alone
    if_req = 1; if_addr = 16'h0010; t0 = cyc;
    wait_ack(0, t0, dt);
    if_req = 0;
    chk("fetch_lat", dt, 3);
    chk("fetch_data", if_rdata, 32'hDEAD_BEEF);
    chk("fetch_err", 32'(if_err), 32'h0);
    @(negedge clk);
    chk("fetch_ack_width", 32'(if_ack), 32'h0);
    // store then load
    d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 32'h1234_5678; t0 = cyc;
    wait_ack(1, t0, dt);
    d_req = 0;
    chk("store_mem", mem[16'h0020], 32'h1234_5678);
    chk("store_rdata", d_rdata, 32'h0);
    @(negedge clk);
    d_req = 1; d_we = 0; t0 = cyc;
    wait_ack(1, t0, dt);
    d_req = 0;
    chk("load_data", d_rdata, 32'h1234_5678);
    // reset in the middle of an access
    @(negedge clk);
    if_req = 1; if_addr = 16'h0010;
    @(negedge clk);
    chk("pre_rst_enable", 32'(mem_enable), 32'h1);
    rst = 1; if_req = 0;
    @(negedge clk);
    chk("rst_enable", 32'(mem_enable), 32'h0);
    rst = 0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_no_ack", 32'(if_ack), 32'h0);
    end
    // contention: both held, pointer reset to fetch so data wins first
    if_req = 1; if_addr = 16'h0030; d_req = 1; d_we = 0; d_addr = 16'h0040; t0 = cyc; prev = t0;
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!if_ack && !d_ack && n < 60);
      who = d_ack ? 1 : 0;
      chk("rr_ack_seen", 32'(if_ack | d_ack), 32'h1);
      chk("rr_order", who, exp_ord[i]);
      chk("rr_spacing", cyc - prev, i == 0 ? 3 : 4);
      chk("rr_data", who ? d_rdata : if_rdata, who ? 32'hBBBB_0002 : 32'hAAAA_0001);
      prev = cyc;
    end
    if_req = 0; d_req = 0;
    repeat (2) @(negedge clk);
    // ready stuck high: first-cycle ready must be ignored
    mode = 1;
    @(negedge clk);
    if_req = 1; if_addr = 16'h0010; t0 = cyc;
    wait_ack(0, t0, dt);
    if_req = 0;
    chk("ready_hi_lat", dt, 3);
    chk("ready_hi_data", if_rdata, 32'hDEAD_BEEF);
    // ready stuck low: timeout
    @(negedge clk);
    mode = 2;
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 16'h0020; t0 = cyc;
    wait_ack(1, t0, dt);
    d_req = 0;
    chk("tmo_lat", dt, TMO + 1);
    chk("tmo_err", 32'(d_err), 32'h1);
    chk("tmo_rdata", d_rdata, 32'h0);
    @(negedge clk);
    mode = 0;
    @(negedge clk);
    d_req = 1; t0 = cyc;
    wait_ack(1, t0, dt);
    d_req = 0;
    chk("post_tmo_lat", dt, 3);
    chk("post_tmo_err", 32'(d_err), 32'h0);
    chk("post_tmo_data", d_rdata, 32'h1234_5678);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
